// File: rtl/snake_timer_ctrl_if.sv
// Bundle between the game FSM and the elapsed-time controller: control pulses one
// way, BCD digits and status flags the other way.
interface snake_timer_ctrl_if;
  logic       start;
  logic       pause;
  logic       clear;
  logic       game_over;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic       running;
  logic       expired;
  logic       tick;

  // Game FSM side
  modport master (
    output start, pause, clear, game_over,
    input  digit0, digit1, digit2, digit3, running, expired, tick
  );

  // Timer controller side
  modport slave (
    input  start, pause, clear, game_over,
    output digit0, digit1, digit2, digit3, running, expired, tick
  );
endinterface

// File: rtl/snake_timer_ctrl.sv
// Elapsed-time controller for the snake game: one-second prescaler, run/pause/done
// sequencing and a cascaded 4-digit BCD counter that saturates at 9999.
module snake_timer_ctrl #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input logic              CLOCK_50,
  input logic              resetn,
  snake_timer_ctrl_if.slave ctrl_io
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0][3:0] digit_q, digit_d, digit_inc;
  logic            tick_q, tick_d;
  logic            expired_q, expired_d;
  logic            running_q, running_d;

  // BCD increment: each digit wraps 9->0 and carries only while all lower digits wrap
  always_comb begin
    logic carry;
    digit_inc = digit_q;
    carry     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (digit_q[i] >= 4'd9) begin
          digit_inc[i] = 4'd0;
        end else begin
          digit_inc[i] = digit_q[i] + 4'd1;
          carry        = 1'b0;
        end
      end
    end
  end

  // Next-state: clear beats game_over beats start/pause
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    digit_d   = digit_q;
    tick_d    = 1'b0;
    expired_d = expired_q;

    if (ctrl_io.clear) begin
      state_d   = StIdle;
      presc_d   = '0;
      digit_d   = '0;
      expired_d = 1'b0;
    end else if (ctrl_io.game_over && (state_q == StRun || state_q == StPause)) begin
      state_d   = StDone;
      expired_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ctrl_io.start) begin
            state_d = StRun;
            presc_d = '0;
          end
        end
        StRun: begin
          if (ctrl_io.pause) state_d = StPause;
          if (presc_q == PrescLast) begin
            presc_d = '0;
            if (digit_q == 16'h9999) begin
              // Saturation: no increment, no tick; this overrides a coincident pause
              state_d   = StDone;
              expired_d = 1'b1;
            end else begin
              digit_d = digit_inc;
              tick_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        StPause: begin
          // Prescaler keeps its held value so paused time is never counted
          if (ctrl_io.pause || ctrl_io.start) state_d = StRun;
        end
        StDone: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign running_d = (state_d == StRun);

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      digit_q   <= '0;
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      digit_q   <= digit_d;
      tick_q    <= tick_d;
      expired_q <= expired_d;
      running_q <= running_d;
    end
  end

  assign ctrl_io.digit0  = digit_q[0];
  assign ctrl_io.digit1  = digit_q[1];
  assign ctrl_io.digit2  = digit_q[2];
  assign ctrl_io.digit3  = digit_q[3];
  assign ctrl_io.running = running_q;
  assign ctrl_io.expired = expired_q;
  assign ctrl_io.tick    = tick_q;

endmodule

// File: tb/tb_snake_timer_ctrl.sv
// Bench for snake_timer_ctrl with TICK_DIV=4: expected digit values are queued when
// counting is started and popped by a monitor on every tick.
module tb_snake_timer_ctrl;

  localparam int unsigned TickDiv = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  snake_timer_ctrl_if bus ();

  snake_timer_ctrl #(
    .TICK_DIV(TickDiv)
  ) dut (
    .CLOCK_50(clk),
    .resetn  (resetn),
    .ctrl_io (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] sb_q[$];
  logic [15:0] digits;

  assign digits = {bus.digit3, bus.digit2, bus.digit1, bus.digit0};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Drive one cycle of pulses at a falling edge; they are sampled by the next rising edge
  task automatic step(input logic s, input logic p, input logic c, input logic g);
    bus.start     = s;
    bus.pause     = p;
    bus.clear     = c;
    bus.game_over = g;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.pause     = 1'b0;
    bus.clear     = 1'b0;
    bus.game_over = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) sb_q.push_back(to_bcd(i));
  endtask

  // Every tick must match the next queued digit value
  always @(negedge clk) begin
    if (bus.tick === 1'b1) begin
      if (sb_q.size() == 0) check_eq("tick_unexpected", 32'(bus.tick), 32'd0);
      else check_eq("tick_digits", 32'(digits), 32'(sb_q.pop_front()));
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.clear = 1'b0;
    bus.game_over = 1'b0;

    // 1. reset then idle
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_digits", 32'(digits), 32'h0);
    check_eq("rst_running", 32'(bus.running), 32'd0);
    check_eq("rst_expired", 32'(bus.expired), 32'd0);
    check_eq("rst_tick", 32'(bus.tick), 32'd0);
    resetn = 1'b1;
    step(1'b0, 1'b1, 1'b0, 1'b0);  // pause ignored in IDLE
    idle(19);
    check_eq("idle_digits", 32'(digits), 32'h0);
    check_eq("idle_running", 32'(bus.running), 32'd0);

    // 2. basic counting
    push_range(1, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("start_running", 32'(bus.running), 32'd1);
    idle(3);
    check_eq("tick_early", 32'(bus.tick), 32'd0);
    idle(1);
    check_eq("tick_first", 32'(bus.tick), 32'd1);
    idle(8);
    check_eq("count_3", 32'(digits), 32'h0003);

    // 3. pause/resume; start in RUN ignored
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("start_in_run", 32'(bus.running), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("paused_running", 32'(bus.running), 32'd0);
    idle(10);
    check_eq("paused_digits", 32'(digits), 32'h0003);
    push_range(4, 4);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("resume_running", 32'(bus.running), 32'd1);
    idle(1);
    check_eq("resume_no_tick", 32'(bus.tick), 32'd0);
    idle(1);
    check_eq("resume_tick", 32'(bus.tick), 32'd1);

    // 4. cascade through 0100 and saturation at 9999
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("clear_digits", 32'(digits), 32'h0);
    push_range(1, 9999);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(400);
    check_eq("cascade_0100", 32'(digits), 32'h0100);
    idle(39596);
    check_eq("reach_9999", 32'(digits), 32'h9999);
    check_eq("reach_expired", 32'(bus.expired), 32'd0);
    idle(3);
    check_eq("pre_sat_running", 32'(bus.running), 32'd1);
    idle(1);
    check_eq("sat_expired", 32'(bus.expired), 32'd1);
    check_eq("sat_running", 32'(bus.running), 32'd0);
    check_eq("sat_tick", 32'(bus.tick), 32'd0);
    check_eq("sat_digits", 32'(digits), 32'h9999);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle(4);
    check_eq("done_hold_running", 32'(bus.running), 32'd0);
    check_eq("done_hold_expired", 32'(bus.expired), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("clr_done_digits", 32'(digits), 32'h0);
    check_eq("clr_done_expired", 32'(bus.expired), 32'd0);
    check_eq("clr_done_running", 32'(bus.running), 32'd0);

    // 5a. game_over on a terminal cycle
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("go_term_tick", 32'(bus.tick), 32'd0);
    check_eq("go_term_digits", 32'(digits), 32'h0);
    check_eq("go_term_running", 32'(bus.running), 32'd0);
    check_eq("go_term_expired", 32'(bus.expired), 32'd0);
    idle(6);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // 5b. pause on a terminal cycle, then resume from a wrapped prescaler
    push_range(1, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("pause_term_tick", 32'(bus.tick), 32'd1);
    check_eq("pause_term_running", 32'(bus.running), 32'd0);
    idle(5);
    push_range(2, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_eq("wrap_no_tick", 32'(bus.tick), 32'd0);
    idle(1);
    check_eq("wrap_tick", 32'(bus.tick), 32'd1);

    // 5c. clear with game_over; start+pause combinations
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("clr_go_digits", 32'(digits), 32'h0);
    check_eq("clr_go_running", 32'(bus.running), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("sp_idle_run", 32'(bus.running), 32'd1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("sp_run_pause", 32'(bus.running), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("sp_pause_run", 32'(bus.running), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // 6. reset mid-count overrides start and game_over
    push_range(1, 42);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(168);
    check_eq("pre_rst_0042", 32'(digits), 32'h0042);
    idle(2);
    resetn = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b1);
    resetn = 1'b1;
    check_eq("midrst_digits", 32'(digits), 32'h0);
    check_eq("midrst_running", 32'(bus.running), 32'd0);
    check_eq("midrst_tick", 32'(bus.tick), 32'd0);
    push_range(1, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    check_eq("post_rst_no_tick", 32'(bus.tick), 32'd0);
    idle(1);
    check_eq("post_rst_tick", 32'(bus.tick), 32'd1);

    idle(1);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
